// File: rtl/pool_buf_pkg.sv
// pool_buf_pkg: shared constants and frame state for the pooled pixel bank arbiter.
package pool_buf_pkg;
    localparam int DATA_W  = 128;
    localparam int BANK_EE = 0;
    localparam int BANK_EO = 1;
    localparam int BANK_OE = 2;
    localparam int BANK_OO = 3;
    typedef enum logic {ST_FILL, ST_POOL} state_t;
endpackage

// File: rtl/pool_buf_addr_map.sv
// pool_buf_addr_map: maps a pixel write or a pooled-window read onto bank selects and the shared bank address.
module pool_buf_addr_map #(
    parameter int IN_WIDTH = 28,
    parameter int ADDR_W   = 16
) (
    input  logic              sel_rd,
    input  logic [15:0]       row,
    input  logic [15:0]       col,
    output logic [3:0]        cs,
    output logic [ADDR_W-1:0] addr
);
    localparam int HALF = IN_WIDTH / 2;
    always_comb begin
        cs   = sel_rd ? 4'b1111 : 4'b0001 << {row[0], col[0]};
        addr = sel_rd ? ADDR_W'(32'(row) * HALF + 32'(col))
                      : ADDR_W'(32'(row >> 1) * HALF + 32'(col >> 1));
    end
endmodule

// File: rtl/pool_pixel_bank_arbiter.sv
// pool_pixel_bank_arbiter: arbitrates four pixel banks between the conv writer and the maxpool reader.
// Define POOL_RD_OUT_REG_EN to register the window read data (2-cycle read latency instead of 1).
module pool_pixel_bank_arbiter #(
    parameter int DATA_W       = pool_buf_pkg::DATA_W,
    parameter int IN_WIDTH     = 28,
    parameter int ADDR_W       = 16,
    parameter int MAX_RD_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [15:0]       wr_row,
    input  logic [15:0]       wr_col,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [15:0]       rd_row,
    input  logic [15:0]       rd_col,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_ee,
    output logic [DATA_W-1:0] rd_data_eo,
    output logic [DATA_W-1:0] rd_data_oe,
    output logic [DATA_W-1:0] rd_data_oo,
    output logic [3:0]        bank_cs,
    output logic [3:0]        bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata_ee,
    input  logic [DATA_W-1:0] bank_rdata_eo,
    input  logic [DATA_W-1:0] bank_rdata_oe,
    input  logic [DATA_W-1:0] bank_rdata_oo,
    input  logic              pool_done,
    output logic              pixel_store_done
);
    import pool_buf_pkg::*;
    localparam int FRAME = IN_WIDTH * IN_WIDTH;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam int STK_W = $clog2(MAX_RD_BURST + 1);
    state_t state, state_n;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_n, cnt_inc;
    logic [15:0] rd_row_q, rd_row_n;
    logic [STK_W-1:0] rd_streak, rd_streak_n;
    logic pool, wr_elig, frame_full, psd_n;
    logic [3:0] map_cs;
    logic [ADDR_W-1:0] map_addr;
    pool_buf_addr_map #(.IN_WIDTH(IN_WIDTH), .ADDR_W(ADDR_W)) u_map (
        .sel_rd(rd_gnt),
        .row(rd_gnt ? rd_row : wr_row),
        .col(rd_gnt ? rd_col : wr_col),
        .cs(map_cs),
        .addr(map_addr)
    );
    assign bank_cs    = (rd_gnt || wr_gnt) ? map_cs : '0;
    assign bank_we    = wr_gnt ? map_cs : '0;
    assign bank_addr  = (rd_gnt || wr_gnt) ? map_addr : '0;
    assign bank_wdata = wr_gnt ? wr_data : '0;
    // Row guard: next-frame writes may only land in row pairs the reader has already passed.
    always_comb begin
        pool        = state == ST_POOL;
        wr_elig     = pool && wr_req && wr_cnt != CNT_W'(FRAME) && (wr_row >> 1) < rd_row_q;
        rd_gnt      = !rst && pool && rd_req && !(wr_elig && rd_streak == STK_W'(MAX_RD_BURST));
        wr_gnt      = !rst && (pool ? wr_elig && !rd_gnt : wr_req);
        cnt_inc     = wr_cnt + CNT_W'(wr_gnt);
        frame_full  = cnt_inc == CNT_W'(FRAME);
        state_n     = state;
        wr_cnt_n    = cnt_inc;
        rd_row_n    = rd_gnt ? rd_row : rd_row_q;
        rd_streak_n = (wr_gnt || !wr_elig) ? '0 : rd_streak + STK_W'(rd_gnt);
        psd_n       = 1'b0;
        if (!pool && frame_full) begin
            state_n  = ST_POOL;
            wr_cnt_n = '0;
            rd_row_n = '0;
            psd_n    = 1'b1;
        end
        if (pool && pool_done) begin
            rd_row_n = '0;
            wr_cnt_n = frame_full ? '0 : cnt_inc;
            psd_n    = frame_full;
            state_n  = frame_full ? ST_POOL : ST_FILL;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_FILL;
            wr_cnt           <= '0;
            rd_row_q         <= '0;
            rd_streak        <= '0;
            pixel_store_done <= 1'b0;
        end else begin
            state            <= state_n;
            wr_cnt           <= wr_cnt_n;
            rd_row_q         <= rd_row_n;
            rd_streak        <= rd_streak_n;
            pixel_store_done <= psd_n;
        end
    end
`ifdef POOL_RD_OUT_REG_EN
    logic rd_pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data_ee <= '0;
            rd_data_eo <= '0;
            rd_data_oe <= '0;
            rd_data_oo <= '0;
        end else begin
            rd_pend  <= rd_gnt;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data_ee <= bank_rdata_ee;
                rd_data_eo <= bank_rdata_eo;
                rd_data_oe <= bank_rdata_oe;
                rd_data_oo <= bank_rdata_oo;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else rd_valid <= rd_gnt;
    end
    assign rd_data_ee = bank_rdata_ee;
    assign rd_data_eo = bank_rdata_eo;
    assign rd_data_oe = bank_rdata_oe;
    assign rd_data_oo = bank_rdata_oo;
`endif
endmodule

// File: tb/tb_pool_pixel_bank_arbiter.sv
// tb_pool_pixel_bank_arbiter: directed and random checks of the pixel bank arbiter against a frame-level model.
module tb_pool_pixel_bank_arbiter;
    localparam int DW = 128, IW = 4, HALF = IW / 2, FRAME = IW * IW, BURST = 4;
`ifdef POOL_RD_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    logic clk, rst;
    logic wr_req, rd_req, pool_done;
    logic [15:0] wr_row, wr_col, rd_row, rd_col;
    logic [DW-1:0] wr_data;
    logic wr_gnt, rd_gnt, rd_valid, pixel_store_done;
    logic [DW-1:0] rd_data_ee, rd_data_eo, rd_data_oe, rd_data_oo, bank_wdata;
    logic [3:0] bank_cs, bank_we;
    logic [15:0] bank_addr;
    logic [DW-1:0] rdata [0:3];
    logic [DW-1:0] mem [0:3][0:15];

    pool_pixel_bank_arbiter #(.DATA_W(DW), .IN_WIDTH(IW), .ADDR_W(16), .MAX_RD_BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data_ee(rd_data_ee), .rd_data_eo(rd_data_eo), .rd_data_oe(rd_data_oe), .rd_data_oo(rd_data_oo),
        .bank_cs(bank_cs), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata_ee(rdata[0]), .bank_rdata_eo(rdata[1]), .bank_rdata_oe(rdata[2]), .bank_rdata_oo(rdata[3]),
        .pool_done(pool_done), .pixel_store_done(pixel_store_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Four single-port SRAMs with one-cycle read latency; cleared while reset is held.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rst) begin
                rdata[b] <= '0;
                for (int a = 0; a < 16; a++) mem[b][a] <= '0;
            end else if (bank_cs[b]) begin
                if (bank_we[b]) mem[b][bank_addr[3:0]] <= bank_wdata;
                else rdata[b] <= mem[b][bank_addr[3:0]];
            end
        end
    end

    // Frame-level reference: image indexed by pixel row/col, arbitration from the frame rules.
    bit m_pool, m_psd, g_wr, g_rd;
    int m_cnt, m_rowq, m_streak;
    bit pv [0:2];
    logic [DW-1:0] pd [0:2][0:3];
    logic [DW-1:0] pix [0:7][0:7];
    int n_chk = 0, n_fail = 0, psd_seen = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pool = 0; m_psd = 0; m_cnt = 0; m_rowq = 0; m_streak = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 0;
            for (int k = 0; k < 4; k++) pd[i][k] = '0;
        end
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix[r][c] = '0;
    endtask

    task automatic tick();
        bit wel, erd, ewr, full;
        int ecs, ewe, eaddr, r, c;
        logic [DW-1:0] ewd;
        #3;
        wel = !rst && m_pool && wr_req && m_cnt < FRAME && int'(wr_row) / 2 < m_rowq;
        erd = !rst && m_pool && rd_req && !(wel && m_streak == BURST);
        ewr = !rst && (m_pool ? wel && !erd : wr_req);
        ecs = 0; ewe = 0; eaddr = 0; ewd = '0;
        if (erd) begin
            ecs = 15;
            eaddr = int'(rd_row) * HALF + int'(rd_col);
        end else if (ewr) begin
            r = int'(wr_row); c = int'(wr_col);
            ecs = 1 << ((r % 2) * 2 + c % 2);
            ewe = ecs;
            eaddr = (r / 2) * HALF + c / 2;
            ewd = wr_data;
        end
        chk("wr_gnt", wr_gnt, ewr);
        chk("rd_gnt", rd_gnt, erd);
        chk("bank_cs", bank_cs, ecs);
        chk("bank_we", bank_we, ewe);
        chk("bank_addr", bank_addr, eaddr);
        chk("bank_wdata", bank_wdata, ewd);
        chk("rd_valid", rd_valid, !rst && pv[L]);
        chk("pixel_store_done", pixel_store_done, !rst && m_psd);
        if (!rst && pv[L]) begin
            chk("rd_data_ee", rd_data_ee, pd[L][0]);
            chk("rd_data_eo", rd_data_eo, pd[L][1]);
            chk("rd_data_oe", rd_data_oe, pd[L][2]);
            chk("rd_data_oo", rd_data_oo, pd[L][3]);
        end
        if (pixel_store_done === 1'b1) psd_seen++;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            pv[2] = pv[1];
            for (int k = 0; k < 4; k++) pd[2][k] = pd[1][k];
            pv[1] = erd;
            if (erd)
                for (int k = 0; k < 4; k++)
                    pd[1][k] = pix[2 * int'(rd_row) + k / 2][2 * int'(rd_col) + k % 2];
            if (ewr) pix[wr_row[2:0]][wr_col[2:0]] = wr_data;
            m_psd = 0;
            full = (m_cnt + int'(ewr)) == FRAME;
            m_cnt += int'(ewr);
            if (!m_pool) begin
                m_streak = 0;
                if (full) begin m_pool = 1; m_cnt = 0; m_rowq = 0; m_psd = 1; end
            end else begin
                if (ewr || !wel) m_streak = 0;
                else if (erd) m_streak++;
                if (erd) m_rowq = int'(rd_row);
                if (pool_done) begin
                    m_rowq = 0;
                    if (full) begin m_cnt = 0; m_psd = 1; end
                    else m_pool = 0;
                end
            end
        end
        g_wr = ewr; g_rd = erd;
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int k, n_w;
        rst = 1; wr_req = 0; rd_req = 0; pool_done = 0;
        wr_row = 0; wr_col = 0; rd_row = 0; rd_col = 0; wr_data = '0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        rst = 0;
        for (int n = 0; n < FRAME; n++) begin
            wr_req = 1; wr_row = 16'(n / IW); wr_col = 16'(n % IW); wr_data = rnd_data();
            #1;
            if (n == 6) begin
                chk("map_we_1_2", bank_we, 4'b0100);
                chk("map_addr_1_2", bank_addr, 1);
            end
            tick();
        end
        wr_req = 0;
        tick(); tick();
        chk("psd_once", psd_seen, 1);

        rd_req = 1; rd_row = 1; rd_col = 1;
        #1;
        chk("rd_cs", bank_cs, 4'hf);
        chk("rd_we", bank_we, 4'h0);
        chk("rd_addr", bank_addr, 3);
        tick();
        rd_req = 0;
        repeat (L - 1) tick();
        #1;
        chk("rd_valid_lat", rd_valid, 1);
        chk("rd_data_oo_win", rd_data_oo, pix[3][3]);
        tick();

        rd_req = 1; rd_row = 1; rd_col = 0;
        k = 0; n_w = 0;
        while (n_w < 8 && k < 60) begin
            wr_req = 1; wr_row = 16'(n_w / IW); wr_col = 16'(n_w % IW); wr_data = rnd_data();
            #1;
            chk("burst_pattern", wr_gnt, (k % 5) == 4);
            tick();
            if (g_wr) n_w++;
            k++;
        end
        chk("burst_writes", n_w, 8);
        rd_req = 0;

        wr_req = 1; wr_row = 2; wr_col = 0; wr_data = rnd_data();
        repeat (2) begin
            #1;
            chk("guard_block", wr_gnt, 0);
            tick();
        end
        rd_req = 1; rd_row = 2; rd_col = 0;
        #1;
        chk("guard_rd", rd_gnt, 1);
        tick();
        rd_req = 0;
        #1;
        chk("guard_release", wr_gnt, 1);
        tick();
        for (int n = 9; n < FRAME; n++) begin
            wr_row = 16'(n / IW); wr_col = 16'(n % IW); wr_data = rnd_data();
            pool_done = (n == FRAME - 1);
            tick();
        end
        wr_req = 0; pool_done = 0;
        #1;
        chk("pd_psd", pixel_store_done, 1);
        tick();
        wr_req = 1; wr_row = 0; wr_col = 0; wr_data = rnd_data();
        #1;
        chk("rowq_clear", wr_gnt, 0);
        tick();
        rd_req = 1; rd_row = 1; rd_col = 1;
        #1;
        chk("still_pool", rd_gnt, 1);
        tick();

        rst = 1;
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_gnt", {wr_gnt, rd_gnt}, 0);
        chk("rst_bank_cs", bank_cs, 0);
        tick(); tick();
        rst = 0;
        rd_req = 1; rd_row = 0; rd_col = 1;
        for (int n = 0; n < FRAME; n++) begin
            wr_req = 1; wr_row = 16'(n / IW); wr_col = 16'(n % IW); wr_data = rnd_data();
            #1;
            chk("fill_no_rd", rd_gnt, 0);
            tick();
        end
        rd_req = 0; wr_req = 0;

        for (int i = 0; i < 400; i++) begin
            if (!wr_req || g_wr) begin
                wr_req = $urandom_range(0, 2) != 0;
                wr_row = 16'($urandom_range(0, 3)); wr_col = 16'($urandom_range(0, 3));
                wr_data = rnd_data();
            end
            if (!rd_req || g_rd) begin
                rd_req = $urandom_range(0, 1) != 0;
                rd_row = 16'($urandom_range(0, 1)); rd_col = 16'($urandom_range(0, 1));
            end
            pool_done = $urandom_range(0, 15) == 0;
            rst = (i == 200 || i == 201);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_pixel_bank_arbiter.md
Name: pool_pixel_bank_arbiter

Overview:
Owns the four single-port pixel SRAM banks (even/even, even/odd, odd/even, odd/odd) that feed the layer-3 2x2 maxpool stage. It arbitrates bank access between two requesters: the upstream conv-layer pixel writer (one bank per write) and the maxpool window reader (all four banks per read). It sequences frames with a FILL/POOL state machine and generates pixel_store_done. Next-frame writes overlap pooling of the current frame under a row guard.

Parameters:
DATA_W, 128, pixel word width (8 channels x 16 bit)
IN_WIDTH, 28, input frame width and height in pixels; must be even
ADDR_W, 16, bank address width
MAX_RD_BURST, 4, consecutive read grants allowed while an eligible write waits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_req  in  1  writer request; held with row/col/data until granted
wr_row  in  16  input pixel row
wr_col  in  16  input pixel column
wr_data  in  DATA_W  pixel data
wr_gnt  out  1  write accepted this cycle
rd_req  in  1  maxpool window read request; held until granted
rd_row  in  16  output (pooled) row
rd_col  in  16  output (pooled) column
rd_gnt  out  1  read accepted this cycle
rd_valid  out  1  read data valid
rd_data_ee/eo/oe/oo  out  DATA_W each  window pixels to maxpool inputs
bank_cs  out  4  bank chip selects, bit0=ee, bit1=eo, bit2=oe, bit3=oo
bank_we  out  4  bank write enables
bank_addr  out  ADDR_W  shared bank address
bank_wdata  out  DATA_W  write data to all banks
bank_rdata_ee/eo/oe/oo  in  DATA_W each  bank read data, 1-cycle SRAM latency
pool_done  in  1  one-cycle pulse from maxpool: frame fully pooled
pixel_store_done  out  1  one-cycle pulse: a full frame is resident

Behaviour:
- Reset: state FILL; all outputs 0; wr_cnt=0; rd_row_q=0; rd_streak=0.
- HALF=IN_WIDTH/2.
- Write mapping: bank index={wr_row[0],wr_col[0]}. bank_addr=(wr_row>>1)*HALF+(wr_col>>1). Exactly one bank_cs/bank_we bit is set.
- Read mapping: bank_cs=4'b1111, bank_we=0, bank_addr=rd_row*HALF+rd_col.
- All grants and bank_* signals are combinational in the grant cycle. rd_valid and rd_data_* (=bank_rdata_*) appear the following cycle.
- State FILL:
  - rd_gnt=0. wr_gnt=wr_req.
  - Each grant increments wr_cnt.
  - On the grant that makes wr_cnt=IN_WIDTH*IN_WIDTH: go to POOL, set wr_cnt=0, rd_row_q=0, and pulse pixel_store_done in the next cycle.
- State POOL:
  - Read eligible: rd_req.
  - Write eligible: wr_req, wr_cnt<IN_WIDTH*IN_WIDTH, and (wr_row>>1)<rd_row_q (the row guard).
  - Both eligible: grant read unless rd_streak==MAX_RD_BURST, in which case grant write.
  - rd_streak: +1 on a read grant while a write is eligible; cleared on a write grant or when no write is eligible.
  - A read grant loads rd_row_q=rd_row.
- pool_done in POOL:
  - If wr_cnt==IN_WIDTH*IN_WIDTH (counting a write granted the same cycle): pulse pixel_store_done next cycle, stay in POOL, clear wr_cnt/rd_row_q.
  - Otherwise: go to FILL, keep wr_cnt, clear rd_row_q.
- Next frame complete before pool_done: further writes are held off (wr_gnt=0).
- Reset mid-operation aborts immediately; in-flight rd_valid is dropped.

Optional Feature:
POOL_RD_OUT_REG_EN:
- Defined: rd_data_* pass through an extra register. rd_valid asserts 2 cycles after rd_gnt.
- Undefined: 1-cycle latency, with rd_data_* driven directly from bank_rdata_*.

Decomposition:
- Package pool_buf_pkg holds:
  - DATA_W and bank index constants BANK_EE=0, BANK_EO=1, BANK_OE=2, BANK_OO=3
  - state enum {ST_FILL, ST_POOL}
- Sub-module pool_buf_addr_map: combinational row/col to bank-select and address for both the write and the read mapping.

Test Plan:
- IN_WIDTH=4, 16 back-to-back writes in raster order -> wr_gnt every cycle. Write (1,2) gives bank_we=4'b0100, bank_addr=1. pixel_store_done pulses once, the cycle after the 16th grant.
- POOL, rd_req row1 col1 -> bank_cs=1111, bank_we=0, bank_addr=3. Next cycle rd_valid=1 and rd_data_oo=bank_rdata_oo.
- POOL with rd_row_q=1, wr_row=0 pending and rd_req held high -> grant pattern 4 reads, 1 write, repeating.
- Row guard: wr_row=2 with rd_row_q=1 and rd_req low -> wr_gnt=0. After a read of row 2 is granted, the write is granted next cycle.
- pool_done in the same cycle as the 16th next-frame write -> pixel_store_done pulse, state stays POOL, rd_row_q=0.
- Assert rst mid-POOL -> all outputs 0, state FILL, wr_cnt=0.
- With POOL_RD_OUT_REG_EN defined -> rd_valid 2 cycles after rd_gnt.
